// File: rtl/bubble_access_sequencer_if.sv
// Host-side request/response and timing-generator signals of the bubble access sequencer.
// The sequencer uses the slave modport; the host/generator side uses master.
interface bubble_access_sequencer_if;
    logic        access_request;
    logic [11:0] access_page;
    logic        access_bootloop;
    logic        access_busy;
    logic        access_done;
    logic        access_error;
    logic        position_change;
    logic        coil_run;
    logic        bubble_shift_enable;
    logic        replicator_enable;
    logic        bootloop_enable;
    logic [11:0] current_position;

    modport slave (
        input  access_request, access_page, access_bootloop, position_change, coil_run,
        output access_busy, access_done, access_error, bubble_shift_enable, replicator_enable,
               bootloop_enable, current_position
    );

    modport master (
        output access_request, access_page, access_bootloop, position_change, coil_run,
        input  access_busy, access_done, access_error, bubble_shift_enable, replicator_enable,
               bootloop_enable, current_position
    );
endinterface

// File: rtl/bubble_access_sequencer.sv
// Page-read sequencer for the bubble timing generator: seek, replicate, stream, park.
// Optional rotation watchdog is enabled by defining BUBBLE_TIMEOUT_EN.
module bubble_access_sequencer #(
    parameter int unsigned PAGE_COUNT     = 2053,
    parameter int unsigned READ_LENGTH    = 1200,
    parameter int unsigned TIMEOUT_CYCLES = 2047
) (
    input logic                      master_clock,
    input logic                      reset,
    bubble_access_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StSeek, StReplicate, StStream, StPark, StDone} state_e;

    localparam logic [12:0] PageLimit = 13'(PAGE_COUNT);
    localparam logic [11:0] LastPos   = 12'(PAGE_COUNT - 1);

    state_e      state_q, state_d;
    logic        prev_change_q;
    logic [11:0] position_q, position_next;
    logic [11:0] page_q, page_d;
    logic        bootloop_q, bootloop_d;
    logic        arm_q, arm_d;
    logic [11:0] rotation_q, rotation_d;
    logic        abort_q, abort_d;
    logic        pos_edge;
    logic        watchdog_expired;
    logic        shift_q, rep_q, boot_en_q, busy_q, done_q, error_q;

    assign pos_edge      = bus.position_change & ~prev_change_q;
    assign position_next = !pos_edge              ? position_q :
                           (position_q == LastPos) ? 12'd0 : position_q + 12'd1;

`ifdef BUBBLE_TIMEOUT_EN
    localparam logic [10:0] TimeoutLimit = 11'(TIMEOUT_CYCLES);
    logic [10:0] watchdog_q, watchdog_d;

    always_comb begin
        watchdog_d = '0;
        if ((state_q inside {StSeek, StReplicate, StStream}) && !pos_edge) begin
            watchdog_d = watchdog_q + 11'd1;
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) watchdog_q <= '0;
        else       watchdog_q <= watchdog_d;
    end

    assign watchdog_expired = (state_q inside {StSeek, StReplicate, StStream}) &&
                              (watchdog_q == TimeoutLimit);
`else
    logic unused_timeout;
    assign unused_timeout   = ^TIMEOUT_CYCLES;
    assign watchdog_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        bootloop_d = bootloop_q;
        arm_d      = arm_q;
        rotation_d = rotation_q;
        abort_d    = abort_q;
        unique case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                if (bus.access_request) begin
                    page_d     = bus.access_page;
                    bootloop_d = bus.access_bootloop;
                    if ({1'b0, bus.access_page} >= PageLimit) begin
                        abort_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        // Already on the page: arm now, replicate on the next edge.
                        arm_d   = (position_next == bus.access_page);
                        state_d = StSeek;
                    end
                end
            end
            StSeek: begin
                if (pos_edge && (arm_q || position_next == page_q)) state_d = StReplicate;
            end
            StReplicate: begin
                if (pos_edge) begin
                    rotation_d = 12'(READ_LENGTH);
                    state_d    = StStream;
                end
            end
            StStream: begin
                if (pos_edge && rotation_q != 12'd0) rotation_d = rotation_q - 12'd1;
                if (rotation_q == 12'd0 || (pos_edge && rotation_q == 12'd1)) state_d = StPark;
            end
            StPark: begin
                if (!bus.coil_run) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (watchdog_expired) begin
            abort_d = 1'b1;
            state_d = StPark;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q       <= StIdle;
            prev_change_q <= 1'b0;
            position_q    <= '0;
            page_q        <= '0;
            bootloop_q    <= 1'b0;
            arm_q         <= 1'b0;
            rotation_q    <= '0;
            abort_q       <= 1'b0;
            shift_q       <= 1'b1;
            rep_q         <= 1'b1;
            boot_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_change_q <= bus.position_change;
            position_q    <= position_next;
            page_q        <= page_d;
            bootloop_q    <= bootloop_d;
            arm_q         <= arm_d;
            rotation_q    <= rotation_d;
            abort_q       <= abort_d;
            shift_q       <= !(state_d inside {StSeek, StReplicate, StStream});
            rep_q         <= (state_d != StReplicate);
            boot_en_q     <= bootloop_d && (state_d inside {StSeek, StReplicate, StStream, StPark});
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_d == StDone);
            error_q       <= (state_d == StDone) && abort_d;
        end
    end

    assign bus.bubble_shift_enable = shift_q;
    assign bus.replicator_enable   = rep_q;
    assign bus.bootloop_enable     = boot_en_q;
    assign bus.access_busy         = busy_q;
    assign bus.access_done         = done_q;
    assign bus.access_error        = error_q;
    assign bus.current_position    = position_q;

endmodule

// File: tb/tb_bubble_access_sequencer.sv
// Self-checking bench for bubble_access_sequencer: procedural generator model plus a
// scoreboard of expected completion status checked on every access_done pulse.
module tb_bubble_access_sequencer;

    localparam int unsigned PageCount     = 8;
    localparam int unsigned ReadLength    = 4;
    localparam int unsigned TimeoutCycles = 200;
    localparam int unsigned Rotation      = 480;
    localparam int unsigned PulseWidth    = 3;

    logic master_clock = 1'b0;
    logic reset;

    always #5 master_clock = ~master_clock;

    bubble_access_sequencer_if bus ();

    bubble_access_sequencer #(
        .PAGE_COUNT    (PageCount),
        .READ_LENGTH   (ReadLength),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .master_clock(master_clock),
        .reset       (reset),
        .bus         (bus)
    );

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    logic        expected_error_q[$];
    logic [11:0] pos_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge master_clock);
            #1;
        end
    endtask

    // One rotation of the generator: edge, then checks of the state it implies.
    task automatic rotate(input string tag, input logic exp_rep, input logic exp_shift);
        bus.position_change = 1'b1;
        step();
        pos_exp = (pos_exp == 12'(PageCount - 1)) ? 12'd0 : pos_exp + 12'd1;
        check({tag, "_pos"},   32'(bus.current_position),    32'(pos_exp));
        check({tag, "_rep"},   32'(bus.replicator_enable),   32'(exp_rep));
        check({tag, "_shift"}, 32'(bus.bubble_shift_enable), 32'(exp_shift));
        step(PulseWidth - 1);
        bus.position_change = 1'b0;
        step(Rotation - PulseWidth);
    endtask

    task automatic request(input logic [11:0] page, input logic boot);
        bus.access_request  = 1'b1;
        bus.access_page     = page;
        bus.access_bootloop = boot;
        step();
        bus.access_request  = 1'b0;
    endtask

    always @(negedge master_clock) begin
        if (!reset && bus.access_done) begin
            if (expected_error_q.size() == 0) begin
                check("done_unexpected", 32'(bus.access_done), 32'd0);
            end else begin
                logic e;
                e = expected_error_q.pop_front();
                check("done_error", 32'(bus.access_error), 32'(e));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic got_done;
        bus.access_request  = 1'b0;
        bus.access_page     = '0;
        bus.access_bootloop = 1'b0;
        bus.position_change = 1'b0;
        bus.coil_run        = 1'b0;
        pos_exp             = '0;

        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("rst_shift", 32'(bus.bubble_shift_enable), 32'd1);
        check("rst_rep",   32'(bus.replicator_enable),   32'd1);
        check("rst_boot",  32'(bus.bootloop_enable),     32'd0);
        check("rst_busy",  32'(bus.access_busy),         32'd0);
        check("rst_done",  32'(bus.access_done),         32'd0);
        check("rst_error", 32'(bus.access_error),        32'd0);
        check("rst_pos",   32'(bus.current_position),    32'd0);

        // Seek to page 5, replicate one rotation, stream ReadLength rotations, park.
        expected_error_q.push_back(1'b0);
        bus.coil_run = 1'b1;
        request(12'd5, 1'b1);
        check("seek_shift_fall", 32'(bus.bubble_shift_enable), 32'd0);
        check("seek_busy",       32'(bus.access_busy),         32'd1);
        check("seek_boot",       32'(bus.bootloop_enable),     32'd1);
        for (int i = 1; i <= 4; i++) rotate("seek", 1'b1, 1'b0);
        rotate("rep_start", 1'b0, 1'b0);
        rotate("rep_end", 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) rotate("stream", 1'b1, 1'b0);
        rotate("stream_last", 1'b1, 1'b1);
        check("park_boot", 32'(bus.bootloop_enable), 32'd1);
        check("park_busy", 32'(bus.access_busy),     32'd1);
        bus.coil_run = 1'b0;
        step();
        check("done_after_coil", 32'(bus.access_done), 32'd1);
        step();
        check("done_pulse_end", 32'(bus.access_done), 32'd0);
        check("idle_busy",      32'(bus.access_busy), 32'd0);

        // Edges keep counting while idle; bring the position to 6.
        for (int i = 0; i < 4; i++) rotate("idle", 1'b1, 1'b1);

        // Wrap-around seek 6 -> 7 -> 0 -> 1, with a busy request that must be ignored.
        expected_error_q.push_back(1'b0);
        bus.coil_run = 1'b1;
        request(12'd1, 1'b0);
        check("wrap_shift_fall", 32'(bus.bubble_shift_enable), 32'd0);
        request(12'd3, 1'b1);
        check("busy_req_boot", 32'(bus.bootloop_enable), 32'd0);
        rotate("wrap_e1", 1'b1, 1'b0);
        rotate("wrap_e2", 1'b1, 1'b0);
        rotate("wrap_rep", 1'b0, 1'b0);
        rotate("wrap_rep_end", 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) rotate("wrap_stream", 1'b1, 1'b0);
        rotate("wrap_stream_last", 1'b1, 1'b1);
        bus.coil_run = 1'b0;
        step();
        check("wrap_done", 32'(bus.access_done), 32'd1);
        step();

        // Out-of-range page is rejected without ever shifting.
        expected_error_q.push_back(1'b1);
        bus.access_request  = 1'b1;
        bus.access_page     = 12'(PageCount);
        bus.access_bootloop = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            bus.access_request = 1'b0;
            check("reject_shift", 32'(bus.bubble_shift_enable), 32'd1);
            if (bus.access_done) got_done = 1'b1;
        end
        check("reject_done", 32'(got_done), 32'd1);
        step(3);
        check("reject_idle", 32'(bus.access_busy), 32'd0);

        // Reset during STREAM: abort with no completion pulse.
        expected_error_q.push_back(1'b0);
        bus.coil_run = 1'b1;
        request(12'd7, 1'b1);
        rotate("mid_rep", 1'b0, 1'b0);
        rotate("mid_stream", 1'b1, 1'b0);
        rotate("mid_stream2", 1'b1, 1'b0);
        reset = 1'b1;
        expected_error_q.delete();
        bus.coil_run = 1'b0;
        step();
        check("mid_rst_shift", 32'(bus.bubble_shift_enable), 32'd1);
        check("mid_rst_rep",   32'(bus.replicator_enable),   32'd1);
        check("mid_rst_pos",   32'(bus.current_position),    32'd0);
        check("mid_rst_busy",  32'(bus.access_busy),         32'd0);
        check("mid_rst_done",  32'(bus.access_done),         32'd0);
        reset   = 1'b0;
        pos_exp = '0;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.access_done) got_done = 1'b1;
        end
        check("mid_rst_no_done", 32'(got_done), 32'd0);

`ifdef BUBBLE_TIMEOUT_EN
        // Stalled generator during SEEK: watchdog releases shift and completes with error.
        expected_error_q.push_back(1'b1);
        bus.coil_run = 1'b1;
        request(12'd3, 1'b0);
        for (int i = 0; i < int'(TimeoutCycles) + 20; i++) begin
            if (bus.bubble_shift_enable) break;
            step();
        end
        check("wd_shift_release", 32'(bus.bubble_shift_enable), 32'd1);
        bus.coil_run = 1'b0;
        step();
        check("wd_done", 32'(bus.access_done), 32'd1);
        step();
`endif

        check("sb_empty", 32'(expected_error_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
